xor_encrypt_core: RTL

//  Downstream consumer of the random stimulus driver: accepts one {key, code} block per valid pulse and

---
 rtl/xor_encrypt_core.sv | 108 ++++++++++
 1 files changed

// File: rtl/xor_encrypt_core.sv
// Byte-serial XOR cipher: each accepted {key, code} block is encrypted LANES bytes per cycle
// with a rolling key (key + byte index, mod 256); blocks offered while busy are dropped and counted.
module xor_encrypt_core #(
  parameter int DATA_W = 256,
  parameter int KEY_W  = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] code,
  output logic              in_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_code,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int NBYTES = DATA_W / 8;
  localparam int NCHUNK = DATA_W / (8 * LANES);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] out_code_q, out_code_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [DATA_W-1:0] xbuf;

  // Every byte owns its rolling-key offset; only bytes in the active chunk are rewritten.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    logic [KEY_W-1:0] rkey;
    logic             sel;
    assign rkey = key_q + KEY_W'(gi);
    assign sel  = (idx_q == IDX_W'(gi / LANES));
    assign xbuf[8*gi +: 8] = sel ? (buf_q[8*gi +: 8] ^ rkey) : buf_q[8*gi +: 8];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_d       = key_q;
    buf_d       = buf_q;
    out_code_d  = out_code_q;
    out_valid_d = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          key_d   = key;
          buf_d   = code;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        buf_d = xbuf;
        if (valid && (drop_q != CNT_MAX)) begin
          drop_d = drop_q + 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          out_code_d  = xbuf;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      key_q       <= '0;
      buf_q       <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      buf_q       <= buf_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = ~in_ready;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign drop_cnt  = drop_q;

endmodule
